pep_mmacc_splitc_sxt_body_buffer: RTL and testbench

// - Upstream neighbour of the splitc sample-extract assembly: stores the LWE body b of each in-flight PBS, indexed by PID.
// - Delivers the bodies on boram_sxt_data in sample-extract command order, one per command.
// - Write side: key-switch/body loader. Order side: PID queue pushed by the sequencer when it issues the sxt command.

---
 rtl/pep_mmacc_splitc_sxt_pkg.sv | 16 +
 rtl/fifo_element.sv | 50 +++++
 rtl/pep_mmacc_splitc_sxt_body_pid_queue.sv | 49 ++++
 rtl/pep_mmacc_splitc_sxt_body_buffer.sv | 121 ++++++++++++
 tb/tb_pep_mmacc_splitc_sxt_body_buffer.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pep_mmacc_splitc_sxt_pkg.sv
// Purpose     : shared widths, error bit positions and default sizes for the splitc sxt body buffer.
// Latency     : n/a (declarations only).
// Backpressure: n/a.
package pep_mmacc_splitc_sxt_pkg;
    localparam int TOTAL_PBS_NB        = 16;
    localparam int PID_W               = $clog2(TOTAL_PBS_NB);
    localparam int LWE_COEF_W          = 32;
    localparam int PID_FIFO_DEPTH_DFLT = 8;

    localparam int BORAM_ERR_W         = 2;
    localparam int BORAM_ERR_OVERWRITE = 0;  // body written over an unread body
    localparam int BORAM_ERR_PUSH_FULL = 1;  // PID pushed while the order queue is full

    typedef logic [PID_W-1:0]      pid_t;
    typedef logic [LWE_COEF_W-1:0] body_t;
endpackage

// File: rtl/fifo_element.sv
// Purpose     : small generic synchronous FIFO, any depth, output taken straight from storage registers.
// Latency     : a word written at cycle t is presented at t+1.
// Backpressure: in_rdy low when full; out_dat forced to 0 while empty.
module fifo_element #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             s_rst_n,
    input  logic [WIDTH-1:0] in_dat,
    input  logic             in_vld,
    output logic             in_rdy,
    output logic [WIDTH-1:0] out_dat,
    output logic             out_vld,
    input  logic             out_rdy
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             push;
    logic             pop;

    assign in_rdy  = (cnt != CNT_W'(DEPTH));
    assign out_vld = (cnt != '0);
    assign out_dat = out_vld ? mem[rd_ptr] : '0;
    assign push    = in_vld & in_rdy;
    assign pop     = out_vld & out_rdy;

    // Storage: no reset needed, occupancy decides what is visible.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_dat;
    end

    // Pointers and occupancy, wrapping at DEPTH (need not be a power of 2).
    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end
endmodule

// File: rtl/pep_mmacc_splitc_sxt_body_pid_queue.sv
// Purpose     : ordered PID queue giving the sample-extract command order to the body buffer.
// Latency     : a PID pushed at cycle t is at the head at t+1.
// Backpressure: in_rdy = !full; a push while full is simply not taken.
module pep_mmacc_splitc_sxt_body_pid_queue
    import pep_mmacc_splitc_sxt_pkg::*;
#(
    parameter int DEPTH = PID_FIFO_DEPTH_DFLT
) (
    input  logic             clk,
    input  logic             s_rst_n,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [PID_W-1:0] in_pid,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [PID_W-1:0] out_pid
);
    localparam int PTR_W = $clog2(DEPTH);

    pid_t             mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             full;
    logic             empty;

    // Extra MSB distinguishes full from empty when the index bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign in_rdy  = !full;
    assign out_vld = !empty;
    assign out_pid = mem[rd_ptr[PTR_W-1:0]];

    // PID storage.
    always_ff @(posedge clk) begin
        if (in_vld && !full) mem[wr_ptr[PTR_W-1:0]] <= in_pid;
    end

    // Read/write pointers, natural wrap modulo 2*DEPTH.
    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (in_vld && !full)   wr_ptr <= wr_ptr + 1'b1;
            if (out_rdy && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/pep_mmacc_splitc_sxt_body_buffer.sv
// Purpose     : holds LWE bodies by PID and streams them to sxt in command (PID queue) order.
// Latency     : head ready with its body -> boram_sxt_data_vld after RAM_LATENCY+1 cycles.
// Backpressure: credit loop sized to the output FIFO; reads stall at zero credit, nothing dropped.
module pep_mmacc_splitc_sxt_body_buffer
    import pep_mmacc_splitc_sxt_pkg::*;
#(
    parameter int RAM_LATENCY    = 2,
    parameter int PID_FIFO_DEPTH = PID_FIFO_DEPTH_DFLT
) (
    input  logic                   clk,
    input  logic                   s_rst_n,
    input  logic                   ks_boram_wr_en,
    input  logic [PID_W-1:0]       ks_boram_wr_pid,
    input  logic [LWE_COEF_W-1:0]  ks_boram_wr_data,
    input  logic                   seq_boram_pid_vld,
    output logic                   seq_boram_pid_rdy,
    input  logic [PID_W-1:0]       seq_boram_pid,
    output logic [LWE_COEF_W-1:0]  boram_sxt_data,
    output logic                   boram_sxt_data_vld,
    input  logic                   boram_sxt_data_rdy,
    output logic [BORAM_ERR_W-1:0] boram_error,
    output logic                   boram_rif_wait_dur
);
    localparam int OFIFO_DEPTH = RAM_LATENCY + 1;
    localparam int CRED_W      = $clog2(OFIFO_DEPTH + 1);

    body_t                   ram [TOTAL_PBS_NB];
    logic [TOTAL_PBS_NB-1:0] avail;
    logic [TOTAL_PBS_NB-1:0] avail_nxt;
    logic [CRED_W-1:0]       credit;
    body_t                   rd_dat [RAM_LATENCY];
    logic [RAM_LATENCY-1:0]  rd_vld;
    logic                    head_vld;
    pid_t                    head_pid;
    logic                    issue;
    logic                    ofifo_in_rdy;
    logic                    ofifo_pop;
    logic [BORAM_ERR_W-1:0]  err_nxt;

    pep_mmacc_splitc_sxt_body_pid_queue #(
        .DEPTH   (PID_FIFO_DEPTH)
    ) u_pid_queue (
        .clk     (clk),
        .s_rst_n (s_rst_n),
        .in_vld  (seq_boram_pid_vld),
        .in_rdy  (seq_boram_pid_rdy),
        .in_pid  (seq_boram_pid),
        .out_vld (head_vld),
        .out_rdy (issue),
        .out_pid (head_pid)
    );

    // A slot freed by this cycle's delivery can be reused at once, keeping one body per cycle.
    assign ofifo_pop          = boram_sxt_data_vld & boram_sxt_data_rdy;
    assign issue              = head_vld & avail[head_pid] & ((credit != '0) | ofifo_pop);
    assign boram_rif_wait_dur = head_vld & !avail[head_pid];

    // Body RAM: read-first, so a same-cycle overwrite leaves the new body pending.
    always_ff @(posedge clk) begin
        if (ks_boram_wr_en) ram[ks_boram_wr_pid] <= ks_boram_wr_data;
        rd_dat[0] <= ram[head_pid];
        for (int i = 1; i < RAM_LATENCY; i++) rd_dat[i] <= rd_dat[i-1];
    end

    // Read-valid pipeline matching the RAM latency.
    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            rd_vld <= '0;
        end else begin
            rd_vld[0] <= issue;
            for (int i = 1; i < RAM_LATENCY; i++) rd_vld[i] <= rd_vld[i-1];
        end
    end

    // Availability: issue clears the head slot, a write sets its slot; set wins on collision.
    always_comb begin
        avail_nxt = avail;
        if (issue)          avail_nxt[head_pid]        = 1'b0;
        if (ks_boram_wr_en) avail_nxt[ks_boram_wr_pid] = 1'b1;
    end

    // Error pulses; an overwrite racing the read of that same slot is legitimate.
    always_comb begin
        err_nxt = '0;
        err_nxt[BORAM_ERR_OVERWRITE] = ks_boram_wr_en & avail[ks_boram_wr_pid] &
                                       !(issue && (head_pid == ks_boram_wr_pid));
        err_nxt[BORAM_ERR_PUSH_FULL] = seq_boram_pid_vld & !seq_boram_pid_rdy;
    end

    // Flags, credit and registered error outputs.
    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            avail       <= '0;
            credit      <= CRED_W'(OFIFO_DEPTH);
            boram_error <= '0;
        end else begin
            avail       <= avail_nxt;
            credit      <= credit - CRED_W'(issue) + CRED_W'(ofifo_pop);
            boram_error <= err_nxt;
        end
    end

    // Credit bounds reads in flight plus buffered bodies, so a returning read always fits.
    always_ff @(posedge clk) begin
        if (s_rst_n && rd_vld[RAM_LATENCY-1]) assert (ofifo_in_rdy);
    end

    fifo_element #(
        .WIDTH   (LWE_COEF_W),
        .DEPTH   (OFIFO_DEPTH)
    ) u_out_fifo (
        .clk     (clk),
        .s_rst_n (s_rst_n),
        .in_dat  (rd_dat[RAM_LATENCY-1]),
        .in_vld  (rd_vld[RAM_LATENCY-1]),
        .in_rdy  (ofifo_in_rdy),
        .out_dat (boram_sxt_data),
        .out_vld (boram_sxt_data_vld),
        .out_rdy (boram_sxt_data_rdy)
    );
endmodule

// File: tb/tb_pep_mmacc_splitc_sxt_body_buffer.sv
// Bench for the sxt body buffer: directed scenarios, transaction-level model, per-cycle compare.
// Model: PID order queue, per-slot body/avail, list of issued bodies with their due cycle.
// Inputs driven just after negedge, outputs compared on negedge.
module tb_pep_mmacc_splitc_sxt_body_buffer;
    import pep_mmacc_splitc_sxt_pkg::*;

    localparam int L  = 2;
    localparam int QD = 8;

    logic                   clk;
    logic                   s_rst_n;
    logic                   ks_boram_wr_en;
    logic [PID_W-1:0]       ks_boram_wr_pid;
    logic [LWE_COEF_W-1:0]  ks_boram_wr_data;
    logic                   seq_boram_pid_vld;
    logic                   seq_boram_pid_rdy;
    logic [PID_W-1:0]       seq_boram_pid;
    logic [LWE_COEF_W-1:0]  boram_sxt_data;
    logic                   boram_sxt_data_vld;
    logic                   boram_sxt_data_rdy;
    logic [BORAM_ERR_W-1:0] boram_error;
    logic                   boram_rif_wait_dur;

    pep_mmacc_splitc_sxt_body_buffer #(
        .RAM_LATENCY        (L),
        .PID_FIFO_DEPTH     (QD)
    ) dut (
        .clk                (clk),
        .s_rst_n            (s_rst_n),
        .ks_boram_wr_en     (ks_boram_wr_en),
        .ks_boram_wr_pid    (ks_boram_wr_pid),
        .ks_boram_wr_data   (ks_boram_wr_data),
        .seq_boram_pid_vld  (seq_boram_pid_vld),
        .seq_boram_pid_rdy  (seq_boram_pid_rdy),
        .seq_boram_pid      (seq_boram_pid),
        .boram_sxt_data     (boram_sxt_data),
        .boram_sxt_data_vld (boram_sxt_data_vld),
        .boram_sxt_data_rdy (boram_sxt_data_rdy),
        .boram_error        (boram_error),
        .boram_rif_wait_dur (boram_rif_wait_dur)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit chk_en      = 0;

    typedef struct {
        logic [LWE_COEF_W-1:0] dat;
        int                    due;
    } out_t;

    int                    m_q[$];
    bit                    m_avail[TOTAL_PBS_NB];
    logic [LWE_COEF_W-1:0] m_body[TOTAL_PBS_NB];
    out_t                  m_out[$];
    logic [1:0]            m_err = '0;
    logic [LWE_COEF_W-1:0] seen[$];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a body leaves RAM_LATENCY+1 cycles after its PID is taken from the queue; at most
    // L+1 bodies may be issued but not yet delivered, counting a delivery in the same cycle.
    always @(posedge clk) begin : model
        bit   qfull;
        bit   iss;
        int   h;
        out_t e;
        if (!s_rst_n) begin
            m_q.delete();
            m_out.delete();
            foreach (m_avail[i]) m_avail[i] = 0;
            m_err = '0;
        end else begin
            qfull = (m_q.size() == QD);
            if (m_out.size() > 0 && m_out[0].due <= cyc && boram_sxt_data_rdy)
                void'(m_out.pop_front());
            iss = (m_q.size() > 0) && m_avail[m_q[0]] && (m_out.size() < L + 1);
            h   = iss ? m_q[0] : -1;
            m_err[0] = ks_boram_wr_en && m_avail[ks_boram_wr_pid] && !(h == int'(ks_boram_wr_pid));
            m_err[1] = seq_boram_pid_vld && qfull;
            if (iss) begin
                e.dat = m_body[h];
                e.due = cyc + L + 1;
                m_out.push_back(e);
                void'(m_q.pop_front());
                m_avail[h] = 0;
            end
            if (ks_boram_wr_en) begin
                m_avail[ks_boram_wr_pid] = 1;
                m_body[ks_boram_wr_pid]  = ks_boram_wr_data;
            end
            if (seq_boram_pid_vld && !qfull) m_q.push_back(int'(seq_boram_pid));
        end
        cyc++;
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin : compare
        bit ev;
        if (chk_en) begin
            ev = (m_out.size() > 0) && (m_out[0].due <= cyc);
            chk("vld", 64'(boram_sxt_data_vld), 64'(ev));
            if (ev) chk("data", 64'(boram_sxt_data), 64'(m_out[0].dat));
            chk("pid_rdy", 64'(seq_boram_pid_rdy), 64'(m_q.size() < QD));
            chk("error", 64'(boram_error), 64'(m_err));
            chk("wait_dur", 64'(boram_rif_wait_dur),
                64'((m_q.size() > 0) && !m_avail[m_q[0]]));
            if (boram_sxt_data_vld && boram_sxt_data_rdy) seen.push_back(boram_sxt_data);
        end
    end

    task automatic step();
        @(negedge clk);
        ks_boram_wr_en    = 1'b0;
        seq_boram_pid_vld = 1'b0;
    endtask

    task automatic wr(input int p, input logic [LWE_COEF_W-1:0] d);
        ks_boram_wr_en   = 1'b1;
        ks_boram_wr_pid  = PID_W'(p);
        ks_boram_wr_data = d;
        step();
    endtask

    task automatic push(input int p);
        seq_boram_pid_vld = 1'b1;
        seq_boram_pid     = PID_W'(p);
        step();
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_vld"},  64'(boram_sxt_data_vld), 64'(0));
        chk({tag, "_data"}, 64'(boram_sxt_data),     64'(0));
        chk({tag, "_err"},  64'(boram_error),        64'(0));
        chk({tag, "_wait"}, 64'(boram_rif_wait_dur), 64'(0));
        chk({tag, "_rdy"},  64'(seq_boram_pid_rdy),  64'(1));
    endtask

    initial begin
        s_rst_n            = 1'b0;
        ks_boram_wr_en     = 1'b0;
        ks_boram_wr_pid    = '0;
        ks_boram_wr_data   = '0;
        seq_boram_pid_vld  = 1'b0;
        seq_boram_pid      = '0;
        boram_sxt_data_rdy = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        s_rst_n = 1'b1;
        chk_en  = 1'b1;
        step();

        // 1: single body, latency and flag clear.
        wr(3, 'h155);
        push(3);
        repeat (L) step();
        chk("t1_vld_early", 64'(boram_sxt_data_vld), 64'(0));
        step();
        chk("t1_vld", 64'(boram_sxt_data_vld), 64'(1));
        chk("t1_data", 64'(boram_sxt_data), 64'h155);
        push(3);
        step();
        chk("t1_avail_cleared", 64'(boram_rif_wait_dur), 64'(1));
        wr(3, 'h156);
        repeat (6) step();

        // 2: delivery follows push order, not write order.
        seen.delete();
        push(5);
        push(2);
        wr(2, 'hA2);
        chk("t2_wait_hi", 64'(boram_rif_wait_dur), 64'(1));
        wr(5, 'hB5);
        chk("t2_wait_lo", 64'(boram_rif_wait_dur), 64'(0));
        repeat (8) step();
        chk("t2_count", 64'(seen.size()), 64'(2));
        chk("t2_first", 64'(seen[0]), 64'hB5);
        chk("t2_second", 64'(seen[1]), 64'hA2);

        // 3: back-pressure with 8 bodies, then release.
        seen.delete();
        boram_sxt_data_rdy = 1'b0;
        for (int i = 0; i < 8; i++) wr(i, LWE_COEF_W'(32'h1000 + i));
        for (int i = 0; i < 8; i++) push(i);
        repeat (20) step();
        chk("t3_hold_vld", 64'(boram_sxt_data_vld), 64'(1));
        chk("t3_hold_data", 64'(boram_sxt_data), 64'h1000);
        boram_sxt_data_rdy = 1'b1;
        repeat (14) step();
        chk("t3_count", 64'(seen.size()), 64'(8));
        for (int i = 0; i < 8; i++) chk("t3_order", 64'(seen[i]), 64'(32'h1000 + i));

        // 4: overwrite before read.
        seen.delete();
        wr(1, 'h11);
        wr(1, 'h22);
        chk("t4_err_pulse", 64'(boram_error), 64'(2'b01));
        step();
        chk("t4_err_gone", 64'(boram_error), 64'(0));
        push(1);
        repeat (6) step();
        chk("t4_count", 64'(seen.size()), 64'(1));
        chk("t4_value", 64'(seen[0]), 64'h22);

        // 5: write after push, then queue overflow.
        push(4);
        repeat (2) step();
        chk("t5_wait", 64'(boram_rif_wait_dur), 64'(1));
        wr(4, 'h44);
        repeat (2) step();
        chk("t5_vld_early", 64'(boram_sxt_data_vld), 64'(0));
        step();
        chk("t5_vld", 64'(boram_sxt_data_vld), 64'(1));
        chk("t5_data", 64'(boram_sxt_data), 64'h44);
        for (int i = 0; i < 8; i++) push(8 + i);
        chk("t5_full_rdy", 64'(seq_boram_pid_rdy), 64'(0));
        push(8);
        chk("t5_err_full", 64'(boram_error), 64'(2'b10));
        step();
        chk("t5_err_gone", 64'(boram_error), 64'(0));
        seen.delete();
        for (int i = 0; i < 8; i++) wr(8 + i, LWE_COEF_W'(32'h800 + i));
        repeat (12) step();
        chk("t5_count", 64'(seen.size()), 64'(8));
        for (int i = 0; i < 8; i++) chk("t5_order", 64'(seen[i]), 64'(32'h800 + i));

        // 6: reset with bodies in flight.
        boram_sxt_data_rdy = 1'b0;
        wr(0, 'hA0);
        wr(1, 'hA1);
        wr(2, 'hA2);
        push(0);
        push(1);
        push(2);
        repeat (6) step();
        chk("t6_pre_vld", 64'(boram_sxt_data_vld), 64'(1));
        s_rst_n = 1'b0;
        repeat (2) step();
        chk_reset_outputs("t6_reset");
        s_rst_n            = 1'b1;
        boram_sxt_data_rdy = 1'b1;
        seen.delete();
        repeat (10) step();
        chk("t6_nothing", 64'(seen.size()), 64'(0));
        wr(6, 'h66);
        push(6);
        repeat (6) step();
        chk("t6_count", 64'(seen.size()), 64'(1));
        chk("t6_value", 64'(seen[0]), 64'h66);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
